// File: rtl/demux_1ton_buf.sv
// demux_1ton_buf: registered 1-to-NCH demux with a one-entry valid/ready buffer per channel.
// Optional broadcast to every channel is enabled by defining DEMUX_BCAST_EN.
module demux_1ton_buf #(
    parameter int WIDTH = 16,
    parameter int NCH   = 16,
    parameter int SELW  = 4
) (
    input  logic               clk,
    input  logic               rst,
`ifdef DEMUX_BCAST_EN
    input  logic               bcast,
`endif
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SELW-1:0]    in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [NCH-1:0]     out_valid,
    input  logic [NCH-1:0]     out_ready,
    output logic [7:0]         drop_cnt
);
    localparam int NSEL = 2**SELW;
    logic [NCH-1:0]   valid_q, valid_d, free, ld;
    logic [WIDTH-1:0] data_q [NCH];
    logic [WIDTH-1:0] data_d [NCH];
    logic [7:0]       drop_q, drop_d;
    logic [NSEL-1:0]  free_x, hot_x;
    logic             sel_ok, acc, drop;
    assign free   = ~valid_q | out_ready;
    assign free_x = NSEL'(free);
    assign hot_x  = NSEL'(1) << in_sel;
    assign sel_ok = {1'b0, in_sel} < (SELW+1)'(NCH);
    assign acc    = in_valid && in_ready;
`ifdef DEMUX_BCAST_EN
    assign in_ready = bcast ? &free : (!sel_ok || free_x[in_sel]);
    assign ld       = !acc ? '0 : bcast ? '1 : hot_x[NCH-1:0];
    assign drop     = acc && !bcast && !sel_ok;
`else
    assign in_ready = !sel_ok || free_x[in_sel];
    assign ld       = acc ? hot_x[NCH-1:0] : '0;
    assign drop     = acc && !sel_ok;
`endif
    // A load wins over a drain, so drain+refill keeps the channel valid.
    always_comb begin
        valid_d = ld | (valid_q & ~out_ready);
        drop_d  = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
        for (int k = 0; k < NCH; k++) data_d[k] = ld[k] ? in_data : data_q[k];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            drop_q  <= '0;
            data_q  <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            drop_q  <= drop_d;
            data_q  <= data_d;
        end
    end
    for (genvar g = 0; g < NCH; g++) begin : g_out
        assign out_data[g*WIDTH +: WIDTH] = data_q[g];
    end
    assign out_valid = valid_q;
    assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_demux_1ton_buf.sv
// tb_demux_1ton_buf: randomized + directed stimulus with per-channel expected-word queues.
// NCH=12 with SELW=4 leaves selects 12..15 out of range to exercise the drop counter.
module tb_demux_1ton_buf;
    localparam int W = 16;
    localparam int N = 12;
    localparam int S = 4;
    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W-1:0]   in_data = '0;
    logic [S-1:0]   in_sel = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N*W-1:0] out_data;
    logic [N-1:0]   out_valid;
    logic [N-1:0]   out_ready = '0;
    logic [7:0]     drop_cnt;

    always #5 clk = ~clk;

    demux_1ton_buf #(.WIDTH(W), .NCH(N), .SELW(S)) dut (
        .clk(clk),
        .rst(rst),
`ifdef DEMUX_BCAST_EN
        .bcast(1'b0),
`endif
        .in_data(in_data),
        .in_sel(in_sel),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .drop_cnt(drop_cnt)
    );

    logic [W-1:0] exp_q [N][$];
    int           exp_drop = 0;
    logic         exp_ready = 1'b1;
    bit           acc_p = 0, rst_p = 1, armed = 0;
    int           sel_p = 0;
    logic [W-1:0] dat_p = '0;
    int           n_vec = 0, n_bad = 0;

    function automatic void chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s[%0d] got %h want %h at %0t", nm, k, got, want, $time);
        end
    endfunction

    // One stimulus cycle: commit the previous cycle's outcome to the model, then drive new inputs.
    task automatic cyc(input bit v, input int sel, input logic [W-1:0] d, input logic [N-1:0] ordy, input bit r);
        @(posedge clk);
        #1;
        if (rst_p) begin
            for (int k = 0; k < N; k++) exp_q[k].delete();
            exp_drop = 0;
            armed = 1;
        end else if (acc_p) begin
            if (sel_p < N) exp_q[sel_p].push_back(dat_p);
            else if (exp_drop < 255) exp_drop++;
        end
        rst = r; in_valid = v; in_sel = S'(sel); in_data = d; out_ready = ordy;
        #2;
        exp_ready = (sel >= N) ? 1'b1 : (exp_q[sel].size() == 0 || ordy[sel]);
        acc_p = v && exp_ready; rst_p = r; sel_p = sel; dat_p = d;
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("in_ready", 0, 32'(in_ready), 32'(exp_ready));
            chk("drop_cnt", 0, 32'(drop_cnt), 32'(exp_drop));
            for (int k = 0; k < N; k++) begin
                chk("out_valid", k, 32'(out_valid[k]), 32'(exp_q[k].size() != 0));
                if (exp_q[k].size() != 0) begin
                    chk("out_data", k, 32'(out_data[k*W +: W]), 32'(exp_q[k][0]));
                    if (out_ready[k]) void'(exp_q[k].pop_front());
                end
            end
        end
    end

    initial begin
        logic [N-1:0] all1, bp5, bp0;
        bit           lv, lr;
        int           ls, s;
        logic [W-1:0] ld, d;
        all1 = '1;
        bp5 = all1 & ~(N'(1) << 5);
        bp0 = all1 & ~N'(1);
        cyc(0, 0, '0, '0, 1);
        cyc(0, 0, '0, '0, 1);
        cyc(1, 3, 16'hA5A5, all1, 0);
        cyc(0, 0, '0, all1, 0);
        cyc(0, 0, '0, all1, 0);
        cyc(1, 5, 16'h1111, bp5, 0);
        for (int i = 0; i < 3; i++) cyc(1, 5, 16'h2222, bp5, 0);
        cyc(1, 5, 16'h2222, all1, 0);
        cyc(0, 0, '0, bp5, 0);
        cyc(0, 0, '0, all1, 0);
        cyc(1, 0, 16'h0C0C, bp0, 0);
        for (int i = 1; i < N; i++) cyc(1, i, W'($urandom), bp0, 0);
        cyc(0, 0, '0, bp0, 0);
        cyc(0, 0, '0, all1, 0);
        for (int i = 0; i < 260; i++) cyc(1, 13, W'($urandom), N'($urandom), 0);
        cyc(1, 2, 16'h0202, '0, 0);
        cyc(1, 7, 16'h0707, '0, 0);
        cyc(1, 4, 16'h0404, '0, 1);
        cyc(0, 0, '0, '0, 0);
        lv = 0; lr = 1; ls = 0; ld = '0;
        for (int i = 0; i < 3000; i++) begin
            if (lv && !lr) begin
                s = ls; d = ld;
            end else begin
                s = $urandom_range(0, 15); d = W'($urandom);
            end
            lv = ($urandom_range(0, 9) < 7) || (lv && !lr);
            cyc(lv, s, d, N'($urandom), $urandom_range(0, 299) == 0);
            lr = exp_ready || rst_p; ls = s; ld = d;
        end
        cyc(0, 0, '0, all1, 0);
        cyc(0, 0, '0, all1, 0);
        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/demux_1ton_buf.md
Name: demux_1toN_buf

Overview:
- Parametrised, registered successor to the 1-to-16 combinational data demux.
- Routes one input word to one of NCH output channels, selected by in_sel.
- Each channel has a one-entry holding register with valid/ready handshake, so slow consumers apply back-pressure instead of losing data.
- Sits between the ALU result bus and per-destination consumers: register-file write ports, flag or status sinks.

Parameters:
- WIDTH, 16, data word width in bits.
- NCH, 16, number of output channels (2..64).
- SELW, 4, width of in_sel; must satisfy 2**SELW >= NCH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word to route.
- in_sel  input  SELW  destination channel index.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts input this cycle.
- out_data  output  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  NCH  channel k holds a word.
- out_ready  input  NCH  consumer k takes its word this cycle.
- drop_cnt  output  8  count of words dropped for an out-of-range in_sel.

Behaviour:
- One clock domain (clk). Reset is synchronous, active-high (rst). All state updates on the rising edge of clk.
- Reset values:
  - out_valid = 0 on all channels.
  - out_data = 0 on all channels.
  - drop_cnt = 0.
  - Reset mid-operation discards every buffered word. rst has priority over every other event.
- Channel k is free when !out_valid[k] || out_ready[k]. This free condition is combinational from out_ready.
- in_ready, combinational:
  - 1 when in_sel >= NCH.
  - Otherwise equals free[in_sel].
  - Never depends on in_valid.
- Accept occurs when in_valid && in_ready.
- Valid in_sel:
  - The accepted word loads into channel in_sel's register.
  - out_valid[in_sel] = 1 on the next cycle.
  - Latency is exactly 1 cycle from accept to visible output.
- Out-of-range in_sel:
  - The word is consumed and discarded.
  - drop_cnt increments by 1 and saturates at 255.
  - No channel changes.
- Per-channel register update, priority order:
  1. Accept targeted at k: load in_data, set out_valid[k] = 1.
  2. Else out_valid[k] && out_ready[k]: clear out_valid[k].
  3. Else hold.
- Simultaneous drain and refill of the same channel in one cycle: new word loaded, out_valid stays 1. Full throughput is 1 word/cycle per channel.
- out_data[k] holds its last value after a drain. Its value is don't-care while out_valid[k] = 0; implementation holds it.
- At most one channel loads per cycle (broadcast excepted). Other channels drain independently and concurrently.
- Producer rule: in_data and in_sel must stay stable while in_valid=1 && in_ready=0.
- No state machine beyond the per-channel valid bits and the saturating counter.

Optional Feature:
- Macro: DEMUX_BCAST_EN.
- With the macro defined:
  - Extra input port bcast (1 bit).
  - When bcast=1, in_sel is ignored.
  - in_ready = AND of free[k] over all k.
  - On accept, in_data loads into every channel and all out_valid bits are set next cycle.
  - drop_cnt is unaffected.
  - When bcast=0, behaviour is identical to the base block.
- Without the macro: no bcast port, no broadcast logic.

Test Plan:
- Reset, then route: rst=1 for 2 cycles → out_valid=0, drop_cnt=0. Then send in_data=16'hA5A5, in_sel=3, out_ready=all 1 → next cycle out_valid=16'h0008, out_data[3]=16'hA5A5; following cycle out_valid=0.
- Back-pressure: out_ready[5]=0, send 16'h1111 to sel 5, then 16'h2222 to sel 5 → in_ready=0 on the second word, 16'h1111 held. Raise out_ready[5] → 16'h2222 accepted the same cycle, and out_data[5]=16'h2222 the next cycle with out_valid[5] still 1.
- Per-channel independence: channel 0 blocked (out_ready[0]=0, out_valid[0]=1), send to sel 1..15 back-to-back → all 15 accepted at 1/cycle, channel 0 unchanged.
- Drop counter: NCH=12, SELW=4, send 260 words with in_sel=13 → in_ready=1 throughout, no out_valid change, drop_cnt=255 (saturated).
- Reset mid-operation: fill channels 2 and 7 with out_ready=0, assert rst with in_valid=1 in the same cycle → next cycle out_valid=0, drop_cnt=0, word not loaded.
- DEMUX_BCAST_EN: bcast=1, in_data=16'hBEEF, channel 4 blocked → in_ready=0. Release channel 4 → all out_valid=16'hFFFF next cycle, every out_data=16'hBEEF.
